// File: rtl/async_fifo_wr_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_ctrl_if
//  Purpose  : Bundles the write-side pointer controller's control and status
//             signals. The controller connects through the slave modport.
//             ALMOST_FULL is present only when ASYNC_FIFO_WR_ALMOST_FULL_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface async_fifo_wr_ctrl_if #(
    parameter int P_SIZE = 3
);
    logic                W_INC;
    logic                OVF_CLR;
    logic [P_SIZE:0]     RD_PTR_SYNC;
    logic                W_EN;
    logic [P_SIZE-1:0]   W_ADDR;
    logic [P_SIZE:0]     WR_PTR_GRAY;
    logic                FULL;
    logic [P_SIZE:0]     FILL_LEVEL;
    logic                OVERFLOW;
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
    logic                ALMOST_FULL;
`endif

    // Requester side: issues writes and supplies the synchronized read pointer
    modport master (
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
        input  ALMOST_FULL,
`endif
        output W_INC, OVF_CLR, RD_PTR_SYNC,
        input  W_EN, W_ADDR, WR_PTR_GRAY, FULL, FILL_LEVEL, OVERFLOW
    );

    // Controller side
    modport slave (
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
        output ALMOST_FULL,
`endif
        input  W_INC, OVF_CLR, RD_PTR_SYNC,
        output W_EN, W_ADDR, WR_PTR_GRAY, FULL, FILL_LEVEL, OVERFLOW
    );
endinterface
`default_nettype wire

// File: rtl/async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : async_fifo_wr_ctrl
//  Purpose  : Write-domain pointer controller of a dual-clock FIFO. Keeps the
//             binary and Gray write pointers, gates memory writes with FULL,
//             and derives fill level and a sticky overflow flag from the
//             already-synchronized Gray read pointer.
//             Optional macro ASYNC_FIFO_WR_ALMOST_FULL_EN adds ALMOST_FULL.
//  Revision : 1.0 - initial release
// ============================================================================
module async_fifo_wr_ctrl #(
    parameter int P_SIZE    = 3
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
   ,parameter int AF_THRESH = 6
`endif
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    async_fifo_wr_ctrl_if.slave bus
);

    localparam int c_PTR_W = P_SIZE + 1;

    logic [c_PTR_W-1:0] r_wb;
    logic [c_PTR_W-1:0] r_gray;
    logic               r_full;
    logic [c_PTR_W-1:0] r_fill;
    logic               r_ovf;

    logic               w_wen;
    logic [c_PTR_W-1:0] w_wb_next;
    logic [c_PTR_W-1:0] w_gray_next;
    logic [c_PTR_W-1:0] w_rb;
    logic [c_PTR_W-1:0] w_full_cmp;
    logic [c_PTR_W-1:0] w_fill_next;

    // Write strobe: blocked while full, and forced low during reset
    assign w_wen       = bus.W_INC & ~r_full & ~RST;
    assign w_wb_next   = r_wb + c_PTR_W'(w_wen);
    assign w_gray_next = w_wb_next ^ (w_wb_next >> 1);

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer; in Gray code that is the read pointer with its two MSBs inverted
    assign w_full_cmp  = {~bus.RD_PTR_SYNC[P_SIZE:P_SIZE-1],
                          bus.RD_PTR_SYNC[P_SIZE-2:0]};

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_rb = '0;
        for (int i = 0; i < c_PTR_W; i++) begin
            w_rb[i] = ^(bus.RD_PTR_SYNC >> i);
        end
    end

    // Occupancy as seen from the write side; modulo wrap is intentional
    assign w_fill_next = w_wb_next - w_rb;

    // Pointer, full and fill registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wb   <= '0;
            r_gray <= '0;
            r_full <= 1'b0;
            r_fill <= '0;
        end else begin
            r_wb   <= w_wb_next;
            r_gray <= w_gray_next;
            r_full <= (w_gray_next == w_full_cmp);
            r_fill <= w_fill_next;
        end
    end

    // Sticky overflow: a set in the same cycle as a clear wins
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ovf <= 1'b0;
        end else if (bus.W_INC & r_full) begin
            r_ovf <= 1'b1;
        end else if (bus.OVF_CLR) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
    logic r_af;

    // Almost-full uses the same modulo occupancy as FILL_LEVEL
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_af <= 1'b0;
        end else begin
            r_af <= (w_fill_next >= c_PTR_W'(AF_THRESH));
        end
    end

    assign bus.ALMOST_FULL = r_af;
`endif

    assign bus.W_EN        = w_wen;
    assign bus.W_ADDR      = r_wb[P_SIZE-1:0];
    assign bus.WR_PTR_GRAY = r_gray;
    assign bus.FULL        = r_full;
    assign bus.FILL_LEVEL  = r_fill;
    assign bus.OVERFLOW    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_async_fifo_wr_ctrl
//  Purpose  : Self-checking bench for async_fifo_wr_ctrl (P_SIZE = 3). A
//             counting model of write/read positions predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_async_fifo_wr_ctrl;

    localparam int P     = 3;
    localparam int DEPTH = 8;
    localparam int MODV  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    async_fifo_wr_ctrl_if #(.P_SIZE(P)) bus ();

    async_fifo_wr_ctrl #(.P_SIZE(P)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: positions counted modulo twice the depth
    int m_wb   = 0;
    int m_rb   = 0;
    int m_fill = 0;
    bit m_full = 1'b0;
    bit m_ovf  = 1'b0;
    bit m_af   = 1'b0;
    bit t_inc, t_clr, t_rst;

    function automatic logic [12:0] exp_state();
        logic [3:0] g;
        g = 4'(m_wb ^ (m_wb >> 1));
        return {3'(m_wb % DEPTH), g, m_full, 4'(m_fill), m_ovf};
    endfunction

    function automatic logic [12:0] act_state();
        return {bus.W_ADDR, bus.WR_PTR_GRAY, bus.FULL, bus.FILL_LEVEL, bus.OVERFLOW};
    endfunction

    task automatic set_in(input bit inc, input bit clr, input bit r);
        t_inc = inc; t_clr = clr; t_rst = r;
        if (r) m_rb = 0;
        bus.W_INC       = inc;
        bus.OVF_CLR     = clr;
        rst             = r;
        bus.RD_PTR_SYNC = 4'(m_rb ^ (m_rb >> 1));
        #1;
    endtask

    task automatic tick();
        bit wen;
        @(posedge clk);
        if (t_rst) begin
            m_wb = 0; m_fill = 0; m_full = 0; m_ovf = 0; m_af = 0;
        end else begin
            wen = t_inc && !m_full;
            if (t_inc && m_full) m_ovf = 1;
            else if (t_clr)      m_ovf = 0;
            m_wb   = (m_wb + int'(wen)) % MODV;
            m_fill = (m_wb - m_rb + MODV) % MODV;
            m_full = (m_fill == DEPTH);
            m_af   = (m_fill >= 6);
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(1, 0, 1);
        n_tests++;
        if (bus.W_EN !== 1'b0) begin
            n_fail++; $display("FAIL reset_wen: got %b want 0", bus.W_EN);
        end
        tick();
        n_tests++;
        if (act_state() !== 13'd0) begin
            n_fail++; $display("FAIL reset_state: got %h want 0", act_state());
        end
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
        n_tests++;
        if (bus.ALMOST_FULL !== 1'b0) begin
            n_fail++; $display("FAIL reset_af: got %b want 0", bus.ALMOST_FULL);
        end
`endif
    endtask

    task automatic test_fill_to_full();
        logic [3:0] gray_tab [8];
        gray_tab = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.W_ADDR !== 3'(i) || bus.WR_PTR_GRAY !== gray_tab[i]) begin
                n_fail++;
                $display("FAIL fill_ptr[%0d]: got addr %0d gray %0d want addr %0d gray %0d",
                         i, bus.W_ADDR, bus.WR_PTR_GRAY, i, gray_tab[i]);
            end
            set_in(1, 0, 0);
            n_tests++;
            if (bus.W_EN !== 1'b1) begin
                n_fail++; $display("FAIL fill_wen[%0d]: got %b want 1", i, bus.W_EN);
            end
            tick();
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
            n_tests++;
            if (bus.ALMOST_FULL !== (i >= 5)) begin
                n_fail++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.ALMOST_FULL, i >= 5);
            end
`endif
        end
        n_tests++;
        if (bus.WR_PTR_GRAY !== 4'd12 || bus.FULL !== 1'b1 || bus.FILL_LEVEL !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_full: got gray %0d full %b fill %0d want 12 1 8",
                     bus.WR_PTR_GRAY, bus.FULL, bus.FILL_LEVEL);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0);
            n_tests++;
            if (bus.W_EN !== 1'b0) begin
                n_fail++; $display("FAIL ovf_wen[%0d]: got %b want 0", i, bus.W_EN);
            end
            tick();
            n_tests++;
            if (bus.W_ADDR !== 3'd0 || bus.WR_PTR_GRAY !== 4'd12 || bus.OVERFLOW !== 1'b1) begin
                n_fail++;
                $display("FAIL ovf_hold[%0d]: got addr %0d gray %0d ovf %b want 0 12 1",
                         i, bus.W_ADDR, bus.WR_PTR_GRAY, bus.OVERFLOW);
            end
        end
        set_in(0, 1, 0);
        tick();
        n_tests++;
        if (bus.OVERFLOW !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: got %b want 0", bus.OVERFLOW);
        end
    endtask

    task automatic test_read_release();
        m_rb = 1;
        set_in(0, 0, 0);
        tick();
        n_tests++;
        if (bus.FULL !== 1'b0 || bus.FILL_LEVEL !== 4'd7) begin
            n_fail++; $display("FAIL release: got full %b fill %0d want 0 7", bus.FULL, bus.FILL_LEVEL);
        end
        set_in(1, 0, 0);
        tick();
        n_tests++;
        if (bus.W_ADDR !== 3'd1 || bus.WR_PTR_GRAY !== 4'd13 || bus.FULL !== 1'b1 || bus.FILL_LEVEL !== 4'd8) begin
            n_fail++;
            $display("FAIL refill: got addr %0d gray %0d full %b fill %0d want 1 13 1 8",
                     bus.W_ADDR, bus.WR_PTR_GRAY, bus.FULL, bus.FILL_LEVEL);
        end
    endtask

    task automatic test_same_cycle_clear();
        set_in(1, 1, 0);
        tick();
        n_tests++;
        if (bus.OVERFLOW !== 1'b1) begin
            n_fail++; $display("FAIL set_beats_clear: got %b want 1", bus.OVERFLOW);
        end
        set_in(0, 1, 0);
        tick();
        n_tests++;
        if (bus.OVERFLOW !== 1'b0) begin
            n_fail++; $display("FAIL clear_after_set: got %b want 0", bus.OVERFLOW);
        end
    endtask

    task automatic test_reset_mid_burst();
        set_in(0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0);
            tick();
        end
        set_in(1, 0, 1);
        n_tests++;
        if (bus.W_EN !== 1'b0) begin
            n_fail++; $display("FAIL midrst_wen: got %b want 0", bus.W_EN);
        end
        tick();
        n_tests++;
        if (act_state() !== 13'd0) begin
            n_fail++; $display("FAIL midrst_state: got %h want 0", act_state());
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 15; i++) begin
            m_rb = (m_wb > 4) ? m_wb - 4 : 0;
            set_in(1, 0, 0);
            tick();
        end
        n_tests++;
        if (bus.WR_PTR_GRAY !== 4'd8 || bus.FILL_LEVEL !== 4'd5) begin
            n_fail++;
            $display("FAIL prewrap: got gray %0d fill %0d want 8 5", bus.WR_PTR_GRAY, bus.FILL_LEVEL);
        end
        set_in(1, 0, 0);
        tick();
        n_tests++;
        if (bus.W_ADDR !== 3'd0 || bus.WR_PTR_GRAY !== 4'd0 || bus.FILL_LEVEL !== 4'd6 || bus.FULL !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap: got addr %0d gray %0d fill %0d full %b want 0 0 6 0",
                     bus.W_ADDR, bus.WR_PTR_GRAY, bus.FILL_LEVEL, bus.FULL);
        end
    endtask

    task automatic test_random();
        bit inc, clr, r;
        for (int i = 0; i < 400; i++) begin
            if (((m_wb - m_rb + MODV) % MODV) > 0 && $urandom_range(0, 9) < 4)
                m_rb = (m_rb + 1) % MODV;
            inc = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 99) == 0);
            set_in(inc, clr, r);
            n_tests++;
            if (bus.W_EN !== (inc && !m_full && !r)) begin
                n_fail++;
                $display("FAIL rand_wen[%0d]: got %b want %b", i, bus.W_EN, inc && !m_full && !r);
            end
            tick();
            n_tests++;
            if (act_state() !== exp_state()) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got %h want %h (addr,gray,full,fill,ovf)",
                         i, act_state(), exp_state());
            end
`ifdef ASYNC_FIFO_WR_ALMOST_FULL_EN
            n_tests++;
            if (bus.ALMOST_FULL !== m_af) begin
                n_fail++; $display("FAIL rand_af[%0d]: got %b want %b", i, bus.ALMOST_FULL, m_af);
            end
`endif
        end
    endtask

    initial begin
        bus.W_INC       = 1'b0;
        bus.OVF_CLR     = 1'b0;
        bus.RD_PTR_SYNC = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_fill_to_full();
        test_overflow();
        test_read_release();
        test_same_cycle_clear();
        test_reset_mid_burst();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
